// File: rtl/sst_bank_engine.sv
// Save-state bus initiator: walks ID byte + N_REGS mapper registers, streaming them out (save) or writing them back (load).
// Latency: RD_WAIT cycles per register read, WE_HOLD+1 cycles per register write, one cycle per stream handshake.
// Backpressure: out_valid/out_ready and in_valid/in_ready stall indefinitely; sst_act stays high while stalled.
module sst_bank_engine #(
    parameter int N_REGS  = 16,
    parameter int ID_ADDR = 127,
    parameter int RD_WAIT = 2,
    parameter int WE_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       sst_act,
    output logic [7:0] sst_addr,
    output logic [7:0] sst_dato,
    output logic       sst_we_reg,
    input  logic [7:0] sst_di,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID_RD,
        S_ID_OUT,
        S_ID_CHK,
        S_REG_RD,
        S_REG_OUT,
        S_REG_GET,
        S_REG_WR,
        S_FIN
    } state_t;

    localparam logic [6:0] LAST_IDX  = 7'(N_REGS - 1);
    localparam logic [3:0] RD_WAIT_V = 4'(RD_WAIT);
    localparam logic [7:0] WE_HOLD_V = 8'(WE_HOLD);
    localparam logic [7:0] ID_ADDR_V = 8'(ID_ADDR);

    state_t     state;
    logic       mode_q;     // 0 = save, 1 = load
    logic [6:0] idx;
    logic [3:0] wait_cnt;
    logic [7:0] hold_cnt;
    logic [7:0] id_q;

    // Session sequencer; every output is a register so the mapper bus never sees decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            idx        <= '0;
            wait_cnt   <= '0;
            hold_cnt   <= '0;
            id_q       <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b0;
            sst_act    <= 1'b0;
            sst_addr   <= '0;
            sst_dato   <= '0;
            sst_we_reg <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        sst_act  <= 1'b1;
                        busy     <= 1'b1;
                        sst_addr <= ID_ADDR_V;
                        wait_cnt <= RD_WAIT_V;
                        state    <= S_ID_RD;
                    end
                end
                S_ID_RD: begin
                    // Sample on the last wait cycle so the address has been stable RD_WAIT cycles.
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        id_q <= sst_di;
                        if (mode_q) begin
                            in_ready <= 1'b1;
                            state    <= S_ID_CHK;
                        end else begin
                            out_data  <= sst_di;
                            out_valid <= 1'b1;
                            state     <= S_ID_OUT;
                        end
                    end
                end
                S_ID_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        sst_addr  <= '0;
                        wait_cnt  <= RD_WAIT_V;
                        state     <= S_REG_RD;
                    end
                end
                S_REG_RD: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        out_data  <= sst_di;
                        out_valid <= 1'b1;
                        state     <= S_REG_OUT;
                    end
                end
                S_REG_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            sst_act <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_FIN;
                        end else begin
                            idx      <= idx + 7'd1;
                            sst_addr <= {1'b0, idx + 7'd1};
                            wait_cnt <= RD_WAIT_V;
                            state    <= S_REG_RD;
                        end
                    end
                end
                S_ID_CHK: begin
                    if (in_valid) begin
                        if (in_data == id_q) begin
                            idx      <= '0;
                            sst_addr <= '0;
                            state    <= S_REG_GET;
                        end else begin
                            // Wrong mapper image: abort before any register is touched.
                            in_ready <= 1'b0;
                            sst_act  <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_REG_GET: begin
                    if (in_valid) begin
                        in_ready   <= 1'b0;
                        sst_dato   <= in_data;
                        hold_cnt   <= WE_HOLD_V;
                        sst_we_reg <= 1'b1;
                        state      <= S_REG_WR;
                    end
                end
                S_REG_WR: begin
                    if (sst_we_reg) begin
                        hold_cnt <= hold_cnt - 8'd1;
                        if (hold_cnt == 8'd1) begin
                            sst_we_reg <= 1'b0;
                        end
                    end else begin
                        // Strobe-low gap cycle: address/data still held, advance afterwards.
                        if (idx == LAST_IDX) begin
                            sst_act <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_FIN;
                        end else begin
                            idx      <= idx + 7'd1;
                            sst_addr <= {1'b0, idx + 7'd1};
                            in_ready <= 1'b1;
                            state    <= S_REG_GET;
                        end
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sst_bank_engine.sv
module tb_sst_bank_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic sel = 1'b0;
    logic out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_valid = 1'b0;
    logic [7:0] sst_di;

    logic [7:0] s_out_data, f_out_data, s_sst_addr, f_sst_addr, s_sst_dato, f_sst_dato;
    logic s_out_valid, f_out_valid, s_in_ready, f_in_ready, s_sst_act, f_sst_act;
    logic s_sst_we, f_sst_we, s_busy, f_busy, s_done, f_done, s_err, f_err;

    logic [7:0] out_data, sst_addr, sst_dato;
    logic out_valid, in_ready, sst_act, sst_we_reg, busy, done, err;

    int checks = 0;
    int errors = 0;
    int exp_hold = 8;

    always #5 clk = ~clk;

    sst_bank_engine #(.N_REGS(16), .ID_ADDR(127), .RD_WAIT(2), .WE_HOLD(8)) u_std (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .mode(mode),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
        .sst_act(s_sst_act), .sst_addr(s_sst_addr), .sst_dato(s_sst_dato),
        .sst_we_reg(s_sst_we), .sst_di(sst_di),
        .busy(s_busy), .done(s_done), .err(s_err));

    sst_bank_engine #(.N_REGS(16), .ID_ADDR(127), .RD_WAIT(1), .WE_HOLD(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .mode(mode),
        .out_data(f_out_data), .out_valid(f_out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(f_in_ready),
        .sst_act(f_sst_act), .sst_addr(f_sst_addr), .sst_dato(f_sst_dato),
        .sst_we_reg(f_sst_we), .sst_di(sst_di),
        .busy(f_busy), .done(f_done), .err(f_err));

    assign out_data   = sel ? f_out_data  : s_out_data;
    assign out_valid  = sel ? f_out_valid : s_out_valid;
    assign in_ready   = sel ? f_in_ready  : s_in_ready;
    assign sst_act    = sel ? f_sst_act   : s_sst_act;
    assign sst_addr   = sel ? f_sst_addr  : s_sst_addr;
    assign sst_dato   = sel ? f_sst_dato  : s_sst_dato;
    assign sst_we_reg = sel ? f_sst_we    : s_sst_we;
    assign busy       = sel ? f_busy      : s_busy;
    assign done       = sel ? f_done      : s_done;
    assign err        = sel ? f_err       : s_err;

    // Mapper register file model: regs[i] = 10+i, ID byte 12 at address 127.
    logic [7:0] regs [0:127];
    logic model_init = 1'b1;
    assign sst_di = regs[sst_addr[6:0]];

    always @(posedge clk) begin
        if (model_init) begin
            for (int i = 0; i < 128; i++) regs[i] <= (i < 16) ? 8'(16 + i) : 8'h00;
            regs[127] <= 8'h12;
        end else if (sst_we_reg) begin
            regs[sst_addr[6:0]] <= sst_dato;
        end
    end

    // Bus monitor, sampled mid-cycle.
    logic mon_clr = 1'b0;
    logic [7:0] outq [$];
    int welens [$];
    int done_cnt, err_cnt, we_total, we_len, we_viol, stall_viol, both_viol;
    logic p_we, pv_stall;
    logic [7:0] p_data, cap_addr, cap_dat;

    always @(negedge clk) begin
        if (mon_clr) begin
            outq.delete(); welens.delete();
            done_cnt = 0; err_cnt = 0; we_total = 0; we_len = 0;
            we_viol = 0; stall_viol = 0; both_viol = 0;
            p_we = 1'b0; pv_stall = 1'b0; p_data = 8'h00;
        end else begin
            if (out_valid && out_ready) outq.push_back(out_data);
            if (pv_stall && out_valid && out_data !== p_data) stall_viol++;
            pv_stall = out_valid && !out_ready;
            p_data = out_data;
            if (out_valid && in_ready) both_viol++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (sst_we_reg) begin
                if (!p_we) begin
                    cap_addr = sst_addr; cap_dat = sst_dato; we_len = 0; we_total++;
                end
                we_len++;
                if (sst_addr !== cap_addr || sst_dato !== cap_dat) we_viol++;
            end else if (p_we) begin
                welens.push_back(we_len);
                if (sst_addr !== cap_addr || sst_dato !== cap_dat) we_viol++;
            end
            p_we = sst_we_reg;
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic reinit_model();
        @(posedge clk); #1 model_init = 1'b1;
        @(posedge clk); #1 model_init = 1'b0;
    endtask

    task automatic pulse_start(input logic m);
        @(posedge clk); #1 start = 1'b1; mode = m;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s timeout: busy=%b want 0", name, busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(posedge clk); #1 in_data = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 3000) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_byte timeout: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, sst_act, out_valid, in_ready, sst_we_reg, done, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {busy, sst_act, out_valid, in_ready, sst_we_reg, done, err});
        end
        checks++;
        if (sst_addr !== 8'h00) begin
            errors++; $display("FAIL reset_addr: got %h want 00", sst_addr);
        end
    endtask

    // Save run; bp=1 throttles out_ready to one cycle in three, bp=0 adds a stray start mid-run.
    task automatic test_save(input bit bp, input string name);
        logic [7:0] exp_b;
        int k = 0;
        clear_mon();
        out_ready = ~bp;
        pulse_start(1'b0);
        if (!bp) begin
            repeat (10) @(posedge clk);
            #1 start = 1'b1; mode = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end else begin
            while (busy && k < 3000) begin
                @(posedge clk); #1 out_ready = (k % 3 == 0); k++;
            end
        end
        wait_idle(name);
        out_ready = 1'b0;
        checks++;
        if (outq.size() !== 17) begin
            errors++; $display("FAIL %s count: got %0d want 17", name, outq.size());
        end
        for (int i = 0; i < 17 && i < outq.size(); i++) begin
            exp_b = (i == 0) ? 8'h12 : 8'(8'h10 + i - 1);
            checks++;
            if (outq[i] !== exp_b) begin
                errors++; $display("FAIL %s byte%0d: got %h want %h", name, i, outq[i], exp_b);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL %s done: got %0d want 1", name, done_cnt);
        end
        checks++;
        if (we_total !== 0) begin
            errors++; $display("FAIL %s we: got %0d strobes want 0", name, we_total);
        end
        checks++;
        if (sst_act !== 1'b0 || stall_viol !== 0 || both_viol !== 0) begin
            errors++;
            $display("FAIL %s after: sst_act=%b stall_viol=%0d both_viol=%0d want 0,0,0",
                     name, sst_act, stall_viol, both_viol);
        end
    endtask

    task automatic test_load_ok(input string name);
        clear_mon();
        pulse_start(1'b1);
        send_byte(8'h12);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hA0 + i));
        wait_idle(name);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (regs[i] !== 8'(8'hA0 + i)) begin
                errors++; $display("FAIL %s reg%0d: got %h want %h", name, i, regs[i], 8'(8'hA0 + i));
            end
        end
        checks++;
        if (welens.size() !== 16) begin
            errors++; $display("FAIL %s strobes: got %0d want 16", name, welens.size());
        end
        foreach (welens[i]) begin
            checks++;
            if (welens[i] !== exp_hold) begin
                errors++; $display("FAIL %s hold%0d: got %0d want %0d", name, i, welens[i], exp_hold);
            end
        end
        checks++;
        if (we_viol !== 0 || done_cnt !== 1 || sst_act !== 1'b0 || both_viol !== 0) begin
            errors++;
            $display("FAIL %s wr_stable: we_viol=%0d done=%0d act=%b both=%0d want 0,1,0,0",
                     name, we_viol, done_cnt, sst_act, both_viol);
        end
    endtask

    task automatic test_load_bad();
        clear_mon();
        pulse_start(1'b1);
        send_byte(8'h13);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || sst_act !== 1'b0) begin
            errors++;
            $display("FAIL load_bad pulse: err=%b busy=%b act=%b want 1,0,0", err, busy, sst_act);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt !== 1 || we_total !== 0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL load_bad totals: err=%0d we=%0d done=%0d want 1,0,0",
                     err_cnt, we_total, done_cnt);
        end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        clear_mon();
        pulse_start(1'b1);
        send_byte(8'h12);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i));
        @(negedge clk);
        while (!sst_we_reg && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (sst_we_reg !== 1'b1 || sst_addr !== 8'h05) begin
            errors++; $display("FAIL rst_mid setup: we=%b addr=%h want 1,05", sst_we_reg, sst_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sst_we_reg !== 1'b0 || sst_act !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid async: we=%b act=%b busy=%b want 0,0,0", sst_we_reg, sst_act, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt !== 0 || err_cnt !== 0) begin
            errors++; $display("FAIL rst_mid pulses: done=%0d err=%0d want 0,0", done_cnt, err_cnt);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_init = 1'b0;
        @(negedge clk);
        test_reset();
        test_save(1'b0, "save");
        test_save(1'b1, "save_bp");
        exp_hold = 8;
        test_load_ok("load");
        reinit_model();
        test_load_bad();
        test_reset_mid_write();
        reinit_model();
        test_save(1'b0, "save_after_rst");
        sel = 1'b1;
        exp_hold = 1;
        reinit_model();
        test_save(1'b0, "fast_save");
        test_load_ok("fast_load");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sst_bank_engine.md
Name: sst_bank_engine

Overview:
- Initiator side of the mapper save-state bus.
- Mapper blocks respond to sst_act, sst_addr, sst_we_reg and sst_dato, and return register bytes on sst_di.
- This block walks that register space:
  - Save mode: reads the ID byte plus N_REGS register bytes and streams them out.
  - Load mode: takes a byte stream, checks the ID byte, then writes the registers back.
- Sits between the system save-state controller/DMA and the active mapper.

Parameters:
- N_REGS, 16, number of register addresses transferred (0..N_REGS-1), range 1..127.
- ID_ADDR, 127, sst address holding the mapper index byte.
- RD_WAIT, 2, clk cycles sst_addr is held stable before sst_di is sampled (1..15).
- WE_HOLD, 8, clk cycles sst_we_reg stays high per write. Must span one mapper m2 falling edge (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- mode  in  1  0=save, 1=load; sampled with start
- out_data  out  8  save stream byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when valid&ready
- in_data  in  8  load stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  engine accepts when valid&ready
- sst_act  out  1  save-state session active; freezes mapper logic
- sst_addr  out  8  register address
- sst_dato  out  8  write data to mapper
- sst_we_reg  out  1  register write strobe
- sst_di  in  8  mapper read data
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on ID mismatch (load)

Behaviour:
- Reset state: IDLE. All outputs 0, sst_addr=0. Internal index and wait counter = 0.
- Reset asserted mid-operation: immediate return to IDLE, sst_act and sst_we_reg drop asynchronously, no done/err pulse.
- States:
  - IDLE
  - ID_RD
  - ID_OUT (save) / ID_CHK (load)
  - REG_RD, REG_OUT (save)
  - REG_GET, REG_WR (load)
  - FIN
- IDLE:
  - start=1 latches mode, sets sst_act=1, sst_addr=ID_ADDR, wait counter=RD_WAIT, next ID_RD.
  - start while busy is ignored.
- ID_RD: counts down RD_WAIT cycles; at zero, latches sst_di into the id register.
  - Save → ID_OUT.
  - Load → ID_CHK.
- ID_OUT: out_valid=1 with the id byte. On handshake, idx=0, sst_addr=0, next REG_RD.
- REG_RD: waits RD_WAIT cycles, latches sst_di, next REG_OUT.
- REG_OUT: out_valid=1 holds the byte stable until out_ready. On handshake:
  - idx==N_REGS-1 → FIN.
  - Otherwise idx+1, sst_addr=idx+1, next REG_RD.
- ID_CHK: in_ready=1. On handshake:
  - in_data==id → idx=0, sst_addr=0, next REG_GET.
  - Otherwise pulse err, next IDLE (sst_act drops the same edge). No register is written.
- REG_GET: in_ready=1. On handshake, latch in_data to sst_dato, load the hold counter with WE_HOLD, next REG_WR.
- REG_WR:
  - sst_we_reg=1 for exactly WE_HOLD cycles. sst_addr and sst_dato stay stable for the whole hold and one cycle after.
  - Then sst_we_reg=0 for one cycle.
  - Then either FIN (last idx) or idx+1 → REG_GET.
- FIN: done=1 for one cycle, sst_act=0, next IDLE.
- sst_addr only changes while sst_we_reg=0.
- sst_we_reg is never high outside REG_WR.
- in_ready and out_valid are never high simultaneously.
- Backpressure: out_ready or in_valid low stalls indefinitely; no timeout. sst_act stays 1 throughout.
- Total save stream = 1+N_REGS bytes, load stream = 1+N_REGS bytes, in address order.
- idx width = 7 bits; no wrap occurs because the terminal compare is N_REGS-1.

Test Plan:
- Save, N_REGS=16, mapper model regs = 8'h10+addr, ID=8'h12, out_ready=1 → stream 12,10,11,...,1F. Exactly 17 handshakes, done pulses once, sst_we_reg never high, sst_act low after.
- Save with out_ready toggling 1-of-3 cycles → identical byte sequence, out_data stable while valid & !ready.
- Load, ID matches, bytes A0..AF → model regs 0..15 = A0..AF. Each write strobe is exactly WE_HOLD cycles with stable addr/data, then done.
- Load, first byte 8'h13 vs ID 8'h12 → err pulse, zero sst_we_reg assertions, busy low the next cycle.
- rst_n asserted during REG_WR of index 5 → sst_we_reg and sst_act low immediately. Subsequent start works normally.
- start pulsed again mid-save → ignored. RD_WAIT=1 and WE_HOLD=1 corner runs complete correctly.
